// File: rtl/regfile_mp.sv
// Two-read / two-write register file with same-cycle write bypass and a
// per-register pending scoreboard (set at issue, cleared at writeback).

module regfile_mp_rd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int NUM_WR   = 2
) (
    input  logic [ADDR_W-1:0]              addr,
    input  logic [DATA_W-1:0]              stored,
    input  logic                           pend,
    input  logic [NUM_WR-1:0]              wr_en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
    output logic [DATA_W-1:0]              data,
    output logic                           busy
);
    logic hit;

    always_comb begin
        data = stored;
        hit  = 1'b0;
        // Ascending scan so the highest-numbered write port has the last word.
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w] == addr)) begin
                data = wr_data[w];
                hit  = 1'b1;
            end
        end
        if ((ZERO_REG != 0) && (addr == '0)) data = '0;
        busy = pend & ~hit;
    end
endmodule

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr
);
    localparam int NUM_REGS = 2**ADDR_W;
    localparam int NUM_RD   = 2;
    localparam int NUM_WR   = 2;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             pending;

    logic [NUM_WR-1:0]             wr_en;
    logic [NUM_WR-1:0][ADDR_W-1:0] wr_addr;
    logic [NUM_WR-1:0][DATA_W-1:0] wr_data;
    logic                          claim;

    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_busy;

    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return (ZERO_REG == 0) || (a != '0);
    endfunction

    // Traffic aimed at a hardwired-zero register is dropped before it reaches state.
    assign wr_en   = {wr_en1 && writable(wr_addr1), wr_en0 && writable(wr_addr0)};
    assign wr_addr = {wr_addr1, wr_addr0};
    assign wr_data = {wr_data1, wr_data0};
    assign claim   = claim_en && writable(claim_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs    <= '0;
            pending <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w]) begin
                    regs[wr_addr[w]]    <= wr_data[w];
                    pending[wr_addr[w]] <= 1'b0;
                end
            end
            // Placed last: a new producer's claim beats a same-cycle writeback.
            if (claim) pending[claim_addr] <= 1'b1;
        end
    end

    assign rd_addr = {rd_addr_b, rd_addr_a};

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            regfile_mp_rd #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG),
                .NUM_WR   (NUM_WR)
            ) u_rd (
                .addr    (rd_addr[p]),
                .stored  (regs[rd_addr[p]]),
                .pend    (pending[rd_addr[p]]),
                .wr_en   (wr_en),
                .wr_addr (wr_addr),
                .wr_data (wr_data),
                .data    (rd_data[p]),
                .busy    (rd_busy[p])
            );
        end
    endgenerate

    assign rd_data_a = rd_data[0];
    assign rd_data_b = rd_data[1];
    assign busy_a    = rd_busy[0];
    assign busy_b    = rd_busy[1];
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default instance (32b x 32, zero reg) and a small
// 16b x 8 instance without zero reg, checked against array models.

module tb_regfile_mp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic [4:0]  ra_a, ra_b, wa0, wa1, ca;
    logic [31:0] rd_a, rd_b, wd0, wd1;
    logic        ba, bb, we0, we1, ce;
    // small instance
    logic [2:0]  s_ra_a, s_ra_b, s_wa0, s_wa1, s_ca;
    logic [15:0] s_rd_a, s_rd_b, s_wd0, s_wd1;
    logic        s_ba, s_bb, s_we0, s_we1, s_ce;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_reg [32];
    logic        m_pend [32];
    logic [15:0] s_reg [8];
    logic        s_pend [8];

    regfile_mp u_dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(ra_a), .rd_addr_b(ra_b), .rd_data_a(rd_a), .rd_data_b(rd_b),
        .busy_a(ba), .busy_b(bb),
        .wr_en0(we0), .wr_addr0(wa0), .wr_data0(wd0),
        .wr_en1(we1), .wr_addr1(wa1), .wr_data1(wd1),
        .claim_en(ce), .claim_addr(ca)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_dut_s (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(s_ra_a), .rd_addr_b(s_ra_b), .rd_data_a(s_rd_a), .rd_data_b(s_rd_b),
        .busy_a(s_ba), .busy_b(s_bb),
        .wr_en0(s_we0), .wr_addr0(s_wa0), .wr_data0(s_wd0),
        .wr_en1(s_we1), .wr_addr1(s_wa1), .wr_data1(s_wd1),
        .claim_en(s_ce), .claim_addr(s_ca)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_models();
        for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_pend[i] = 1'b0; end
        for (int i = 0; i < 8; i++)  begin s_reg[i] = '0; s_pend[i] = 1'b0; end
    endtask

    // A read returns whatever the register will hold after this edge.
    task automatic check_main(input string tag);
        logic [31:0] nxt [32];
        nxt = m_reg;
        if (we0 && wa0 != 0) nxt[wa0] = wd0;
        if (we1 && wa1 != 0) nxt[wa1] = wd1;
        chk({tag, ".rd_a"}, rd_a, nxt[ra_a]);
        chk({tag, ".rd_b"}, rd_b, nxt[ra_b]);
        chk({tag, ".busy_a"}, 32'(ba), 32'(m_pend[ra_a] && !(we0 && wa0 == ra_a) && !(we1 && wa1 == ra_a)));
        chk({tag, ".busy_b"}, 32'(bb), 32'(m_pend[ra_b] && !(we0 && wa0 == ra_b) && !(we1 && wa1 == ra_b)));
    endtask

    task automatic check_small(input string tag);
        logic [15:0] nxt [8];
        nxt = s_reg;
        if (s_we0) nxt[s_wa0] = s_wd0;
        if (s_we1) nxt[s_wa1] = s_wd1;
        chk({tag, ".s_rd_a"}, 32'(s_rd_a), 32'(nxt[s_ra_a]));
        chk({tag, ".s_rd_b"}, 32'(s_rd_b), 32'(nxt[s_ra_b]));
        chk({tag, ".s_busy_a"}, 32'(s_ba), 32'(s_pend[s_ra_a] && !(s_we0 && s_wa0 == s_ra_a) && !(s_we1 && s_wa1 == s_ra_a)));
        chk({tag, ".s_busy_b"}, 32'(s_bb), 32'(s_pend[s_ra_b] && !(s_we0 && s_wa0 == s_ra_b) && !(s_we1 && s_wa1 == s_ra_b)));
    endtask

    task automatic commit_models();
        if (!rst_n) begin
            clear_models();
        end else begin
            if (we0 && wa0 != 0) m_reg[wa0] = wd0;
            if (we1 && wa1 != 0) m_reg[wa1] = wd1;
            if (we0) m_pend[wa0] = 1'b0;
            if (we1) m_pend[wa1] = 1'b0;
            if (ce && ca != 0) m_pend[ca] = 1'b1;
            if (s_we0) s_reg[s_wa0] = s_wd0;
            if (s_we1) s_reg[s_wa1] = s_wd1;
            if (s_we0) s_pend[s_wa0] = 1'b0;
            if (s_we1) s_pend[s_wa1] = 1'b0;
            if (s_ce) s_pend[s_ca] = 1'b1;
        end
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; ce = 0; wa0 = '0; wa1 = '0; ca = '0; wd0 = '0; wd1 = '0;
        s_we0 = 0; s_we1 = 0; s_ce = 0; s_wa0 = '0; s_wa1 = '0; s_ca = '0; s_wd0 = '0; s_wd1 = '0;
    endtask

    task automatic settle(input string tag);
        #1;
        if (!rst_n) clear_models();
        check_main(tag);
        check_small(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        commit_models();
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        bit narrow;
        narrow = 1'($urandom_range(0, 1));
        we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1)); ce = 1'($urandom_range(0, 1));
        wa0 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        wa1 = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        ca  = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        ra_a = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        ra_b = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
        wd0 = $urandom; wd1 = $urandom;
        s_we0 = 1'($urandom_range(0, 1)); s_we1 = 1'($urandom_range(0, 1)); s_ce = 1'($urandom_range(0, 1));
        s_wa0 = 3'($urandom); s_wa1 = 3'($urandom); s_ca = 3'($urandom);
        s_ra_a = 3'($urandom); s_ra_b = 3'($urandom);
        s_wd0 = 16'($urandom); s_wd1 = 16'($urandom);
    endtask

    initial begin
        idle();
        clear_models();
        ra_a = 5'd0; ra_b = 5'd5; s_ra_a = 3'd0; s_ra_b = 3'd1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // reset held, then released
        settle("rst_hold");
        chk("rst_rd0", rd_a, 32'h0);
        chk("rst_rd5", rd_b, 32'h0);
        chk("rst_busy", 32'(ba | bb), 32'h0);
        rst_n = 1'b1;
        tick();
        ra_a = 5'd31;
        settle("rst_rel");
        chk("rst_rd31", rd_a, 32'h0);
        tick();

        // write 5, then a half-cycle reset wipes it
        we0 = 1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; ra_a = 5'd5;
        settle("wr5");
        tick();
        idle();
        settle("rd5");
        chk("rd5_val", rd_a, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        clear_models();
        chk("rst_mid_rd5", rd_a, 32'h0);
        #1 rst_n = 1'b1;
        #1 check_main("rst_mid_after");
        tick();

        // a write presented while reset is held is lost
        rst_n = 1'b0;
        we0 = 1; wa0 = 5'd3; wd0 = 32'h1234; ra_a = 5'd3;
        settle("rst_wr");
        tick();
        rst_n = 1'b1;
        idle();
        settle("rst_wr_lost");
        chk("rst_wr_lost_val", rd_a, 32'h0);
        tick();

        // both ports to one address: port 1 wins, bypass included
        we0 = 1; wa0 = 5'd7; wd0 = 32'h1111_1111;
        we1 = 1; wa1 = 5'd7; wd1 = 32'h2222_2222; ra_a = 5'd7;
        settle("pri");
        chk("pri_bypass", rd_a, 32'h2222_2222);
        tick();
        idle();
        settle("pri_next");
        chk("pri_array", rd_a, 32'h2222_2222);
        tick();

        // zero register on both instances
        we0 = 1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF; ce = 1; ca = 5'd0;
        s_we0 = 1; s_wa0 = 3'd0; s_wd0 = 16'hFFFF; s_ce = 1; s_ca = 3'd0;
        ra_a = 5'd0; s_ra_a = 3'd0;
        settle("zero");
        tick();
        idle();
        settle("zero_next");
        chk("zero_rd", rd_a, 32'h0);
        chk("zero_busy", 32'(ba), 32'h0);
        chk("nozero_rd", 32'(s_rd_a), 32'hFFFF);
        chk("nozero_busy", 32'(s_ba), 32'h1);
        tick();

        // scoreboard lifecycle on register 9
        ce = 1; ca = 5'd9; ra_a = 5'd9;
        settle("sb_n");
        tick();
        idle();
        settle("sb_n1");
        chk("sb_busy_n1", 32'(ba), 32'h1);
        tick();
        settle("sb_n2");
        chk("sb_busy_n2", 32'(ba), 32'h1);
        tick();
        we1 = 1; wa1 = 5'd9; wd1 = 32'hABCD;
        settle("sb_n3");
        chk("sb_busy_n3", 32'(ba), 32'h0);
        chk("sb_data_n3", rd_a, 32'hABCD);
        tick();
        idle();
        settle("sb_n4");
        chk("sb_busy_n4", 32'(ba), 32'h0);
        tick();

        // claim and writeback collide on register 12
        ce = 1; ca = 5'd12; ra_a = 5'd12;
        settle("col_pre");
        tick();
        ce = 1; ca = 5'd12; we0 = 1; wa0 = 5'd12; wd0 = 32'h55;
        settle("col");
        tick();
        idle();
        settle("col_next");
        chk("col_busy", 32'(ba), 32'h1);
        chk("col_data", rd_a, 32'h55);
        tick();

        // small instance: fill all 8 on alternating ports, read back pairwise
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i % 2 == 0) begin s_we0 = 1; s_wa0 = 3'(i); s_wd0 = 16'(i * 16'h0101); end
            else            begin s_we1 = 1; s_wa1 = 3'(i); s_wd1 = 16'(i * 16'h0101); end
            settle("fill");
            tick();
        end
        idle();
        for (int i = 0; i < 8; i += 2) begin
            s_ra_a = 3'(i); s_ra_b = 3'(i + 1);
            settle("sweep");
            chk($sformatf("sweep_a%0d", i), 32'(s_rd_a), 32'(i * 16'h0101));
            chk($sformatf("sweep_b%0d", i + 1), 32'(s_rd_b), 32'((i + 1) * 16'h0101));
            tick();
        end

        // random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            rand_inputs();
            rst_n = ($urandom_range(0, 49) != 0);
            settle("rand");
            tick();
        end
        rst_n = 1'b1;
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
